stoch_sat_sub_ctrl: RTL and testbench

Sequencer for one stochastic saturating-subtract datapath (y = max(a - b, 0) as bitstreams).
- Per evaluation: clears the datapath, then streams a warm-up window whose outputs are discarded.
- Then streams a measurement window of `len` bit-pairs and counts output ones into a binary estimate.
- Sits between an upstream bit-pair source (valid/ready) and the datapath instance, with a start/done handshake toward the host.

---
 rtl/stoch_sat_sub_ctrl.sv | 146 ++++++++++++++
 tb/tb_stoch_sat_sub_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stoch_sat_sub_ctrl.sv
// Sequencer for a stochastic saturating-subtract datapath: clear, warm-up, then count output ones.
// Optional stall timeout enabled by defining STOCH_SAT_SUB_CTRL_TIMEOUT_EN.
module stoch_sat_sub_ctrl #(
   parameter int unsigned LEN_WIDTH = 16,
   parameter int unsigned WARMUP    = 8
`ifdef STOCH_SAT_SUB_CTRL_TIMEOUT_EN
   ,parameter int unsigned TIMEOUT  = 255
`endif
) (
   input  logic                 CLK,
   input  logic                 nRST,
   input  logic                 start,
   input  logic [LEN_WIDTH-1:0] len,
   input  logic                 abort,
   input  logic                 in_valid,
   input  logic                 in_a,
   input  logic                 in_b,
   output logic                 in_ready,
   output logic                 dp_nrst,
   output logic                 dp_a,
   output logic                 dp_b,
   input  logic                 dp_y,
   output logic                 busy,
   output logic                 done,
   output logic [LEN_WIDTH-1:0] result,
   output logic                 err
);
   localparam int unsigned WW = (WARMUP > 1) ? $clog2(WARMUP + 1) : 1;

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_WARMUP, S_RUN, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [LEN_WIDTH-1:0] len_q, len_d;
   logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
   logic [LEN_WIDTH-1:0] result_q, result_d;
   logic [WW-1:0]        wcnt_q, wcnt_d;
   logic                 xfer;
   logic                 stall_hit;
   logic                 streaming;

   assign streaming = (state_q == S_WARMUP) || (state_q == S_RUN);
   assign in_ready  = streaming;
   assign xfer      = in_valid & in_ready;
   // Zero the datapath inputs on stalls so its internal state holds.
   assign dp_a      = in_a & xfer;
   assign dp_b      = in_b & xfer;
   assign dp_nrst   = (state_q != S_CLEAR);
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign result    = result_q;

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      wcnt_d   = wcnt_q;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               len_d    = len;
               result_d = '0;
               cnt_d    = '0;
               wcnt_d   = '0;
               state_d  = S_CLEAR;
            end
         end
         S_CLEAR: begin
            if (WARMUP > 0)         state_d = S_WARMUP;
            else if (len_q != '0)   state_d = S_RUN;
            else                    state_d = S_DONE;
         end
         S_WARMUP: begin
            if (xfer) begin
               if (32'(wcnt_q) == WARMUP - 1) begin
                  wcnt_d  = '0;
                  state_d = (len_q != '0) ? S_RUN : S_DONE;
               end else begin
                  wcnt_d = wcnt_q + 1'b1;
               end
            end
         end
         S_RUN: begin
            if (xfer) begin
               cnt_d    = cnt_q + 1'b1;
               result_d = result_q + LEN_WIDTH'(dp_y);
               if (cnt_d == len_q) state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (stall_hit) state_d = S_DONE;
      // abort outranks every other transition, including start in IDLE
      if (abort)     state_d = S_IDLE;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= S_IDLE;
         len_q    <= '0;
         cnt_q    <= '0;
         wcnt_q   <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         wcnt_q   <= wcnt_d;
         result_q <= result_d;
      end
   end

`ifdef STOCH_SAT_SUB_CTRL_TIMEOUT_EN
   localparam int unsigned SW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   logic [SW-1:0] stall_q, stall_d;
   logic          err_q, err_d;

   // Consecutive idle cycles while streaming; any transfer restarts the count.
   assign stall_hit = streaming && (32'(stall_q) == TIMEOUT);
   assign err       = err_q;

   always_comb begin
      stall_d = '0;
      if (streaming && !in_valid && !stall_hit) stall_d = stall_q + 1'b1;
      err_d = err_q;
      if (state_q == S_IDLE && start && !abort) err_d = 1'b0;
      else if (stall_hit && !abort)             err_d = 1'b1;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_q <= '0;
         err_q   <= 1'b0;
      end else begin
         stall_q <= stall_d;
         err_q   <= err_d;
      end
   end
`else
   assign stall_hit = 1'b0;
   assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_stoch_sat_sub_ctrl.sv
// Scoreboard bench for stoch_sat_sub_ctrl: the driver predicts each evaluation's outcome, a monitor checks it.
module tb_stoch_sat_sub_ctrl;
   localparam int TB_W = 8;
`ifdef STOCH_SAT_SUB_CTRL_TIMEOUT_EN
   localparam int TB_TO = 4;
   localparam bit TO_ON = 1'b1;
`else
   localparam bit TO_ON = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        start = 1'b0;
   logic [15:0] len = '0;
   logic        abort = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_a = 1'b0;
   logic        in_b = 1'b0;
   logic        in_ready, dp_nrst, dp_a, dp_b, dp_y, busy, done, err;
   logic [15:0] result;
   logic        junk = 1'b0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int res;
      bit err;
      int lat;
      bit done;
      int xfers;
   } exp_t;
   exp_t sb[$];

   always #5 CLK = ~CLK;

   // Toy datapath: y = a & ~b on transfers, random garbage otherwise (must be ignored).
   assign dp_y = (in_valid && in_ready) ? (dp_a & ~dp_b) : junk;
   initial forever begin
      @(posedge CLK);
      junk = 1'($urandom);
   end

   stoch_sat_sub_ctrl #(
      .LEN_WIDTH(16),
      .WARMUP(TB_W)
`ifdef STOCH_SAT_SUB_CTRL_TIMEOUT_EN
      ,.TIMEOUT(TB_TO)
`endif
   ) dut (
      .CLK(CLK), .nRST(nRST), .start(start), .len(len), .abort(abort),
      .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
      .dp_nrst(dp_nrst), .dp_a(dp_a), .dp_b(dp_b), .dp_y(dp_y),
      .busy(busy), .done(done), .result(result), .err(err)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // stop_kind: 0 none, 1 abort on RUN transfer stop_k, 2 stall after stop_k RUN transfers, 3 async reset after stop_k
   task automatic run_eval(input int l, input int amode, input int vmode, input int stop_kind, input int stop_k);
      bit   pa[$];
      bit   pb[$];
      exp_t e;
      int   n, nrun, idx, c, zrun, stalled;
      bit   v, x, wd;
      n = TB_W + l;
      for (int i = 0; i < n; i++) begin
         case (amode)
            1:       begin pa.push_back(1'b1); pb.push_back(1'b0); end
            2:       begin pa.push_back(1'b1); pb.push_back(1'b1); end
            3:       begin pa.push_back(1'b0); pb.push_back(1'b1); end
            default: begin pa.push_back(1'($urandom)); pb.push_back(1'($urandom)); end
         endcase
      end
      nrun = (stop_kind == 0) ? l : stop_k;
      e.res = 0;
      for (int i = 0; i < nrun; i++) e.res += int'(pa[TB_W + i] & ~pb[TB_W + i]);
      e.xfers = TB_W + nrun;
      e.done  = (stop_kind == 0) || (stop_kind == 2 && TO_ON);
      e.err   = (stop_kind == 2 && TO_ON);
      e.lat   = -1;
      if (stop_kind == 0 && vmode == 0) e.lat = 2 + TB_W + l;
      if (stop_kind == 0 && vmode == 1) e.lat = 1 + 2 * (TB_W + l);
`ifdef STOCH_SAT_SUB_CTRL_TIMEOUT_EN
      if (stop_kind == 2 && vmode == 0) e.lat = 3 + TB_W + stop_k + TB_TO;
`endif
      if (stop_kind == 3) e.res = 0;
      sb.push_back(e);

      start = 1'b1;
      len   = 16'(l);
      @(posedge CLK); #1;
      start = 1'b0;
      len   = 16'($urandom);
      idx = 0; c = 1; zrun = 0; stalled = 0;
      for (int guard = 0; ; guard++) begin
         if (guard == 3000) begin
            checks++; errors++;
            $display("FAIL eval_budget: got busy after %0d cycles expected done", guard);
            abort = 1'b1;
            @(posedge CLK); #1;
            abort = 1'b0;
            break;
         end
         case (vmode)
            0: v = 1'b1;
            1: v = (c % 2 == 0);
            default: begin
               if (zrun >= 2) v = 1'b1;
               else           v = ($urandom_range(0, 3) != 0);
            end
         endcase
         zrun = v ? 0 : zrun + 1;
         if (stop_kind == 2 && idx >= TB_W + stop_k) v = 1'b0;
         in_valid = v;
         in_a = (idx < n) ? pa[idx] : 1'($urandom);
         in_b = (idx < n) ? pb[idx] : 1'($urandom);
         x = v && in_ready;
         abort = (stop_kind == 1 && x && idx == TB_W + stop_k - 1);
         if (stop_kind == 2 && !v) begin
            stalled++;
            if (!TO_ON && stalled == 300) begin
               chk("stall_busy", int'(busy), 1);
               chk("stall_err", int'(err), 0);
               abort = 1'b1;
            end
         end
         if (stop_kind == 3 && idx == TB_W + stop_k) begin
            #2 nRST = 1'b0;
            #1;
            chk("rst_busy", int'(busy), 0);
            chk("rst_result", int'(result), 0);
            chk("rst_ready", int'(in_ready), 0);
            @(posedge CLK); #1;
            nRST = 1'b1;
            break;
         end
         wd = done;
         if (wd) begin
            start = 1'b1;
            len   = 16'($urandom_range(1, 20));
         end
         @(posedge CLK); #1;
         if (x) idx++;
         c++;
         abort = 1'b0;
         if (wd) begin
            chk("start_in_done_ignored", int'(busy), 0);
            start = 1'b0;
            break;
         end
         if (!busy) break;
      end
      in_valid = 1'b0;
      abort    = 1'b0;
   endtask

   // Monitor: tracks each evaluation from busy rise to busy fall and scores it.
   initial begin
      int   cyc, start_cyc, done_cyc, nlow, nx, ntx;
      bit   busy_p, saw, x;
      exp_t e;
      cyc = 0; start_cyc = 0; done_cyc = -1; nlow = 0; nx = 0; ntx = 0;
      busy_p = 1'b0; saw = 1'b0;
      forever begin
         @(negedge CLK);
         cyc++;
         x = in_valid & in_ready;
         chk("dp_gate", int'({dp_a, dp_b}), x ? int'({in_a, in_b}) : 0);
         if (!busy || done) chk("ready_off", int'(in_ready), 0);
         if (busy && !busy_p) begin
            start_cyc = cyc - 1; nlow = 0; nx = 0; saw = 1'b0; done_cyc = -1;
         end
         if (busy) begin
            if (!dp_nrst) begin
               nlow++;
               chk("clear_result", int'(result), 0);
               chk("clear_err", int'(err), 0);
            end
            if (x) nx++;
            if (done) begin saw = 1'b1; done_cyc = cyc; end
         end
         if (!busy && busy_p) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL sb_underflow: got evaluation end expected none");
            end else begin
               e = sb.pop_front();
               ntx++;
               chk("done_pulse", int'(saw), int'(e.done));
               chk("result", int'(result), e.res);
               chk("err", int'(err), int'(e.err));
               chk("xfers", nx, e.xfers);
               chk("clear_cycles", nlow, 1);
               if (e.lat >= 0) chk("latency", done_cyc - start_cyc, e.lat);
               $display("eval %0d: result=%0d exp=%0d done=%0b err=%0b xfers=%0d lat=%0d", ntx, result, e.res,
                        saw, err, nx, (done_cyc < 0) ? -1 : done_cyc - start_cyc);
            end
         end
         busy_p = busy;
      end
   end

   initial begin
      repeat (2) @(posedge CLK);
      #1;
      chk("reset_ready", int'(in_ready), 0);
      chk("reset_dp_nrst", int'(dp_nrst), 1);
      chk("reset_dp_ab", int'({dp_a, dp_b}), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_result", int'(result), 0);
      chk("reset_err", int'(err), 0);
      nRST = 1'b1;
      @(posedge CLK); #1;

      run_eval(10, 1, 0, 0, 0);   // full-rate, all ones
      run_eval(16, 2, 0, 0, 0);   // a=b -> 0
      run_eval(16, 3, 0, 0, 0);   // a<b saturates at 0
      run_eval(0, 0, 0, 0, 0);    // empty measurement window
      run_eval(10, 1, 1, 0, 0);   // toggling valid
      run_eval(10, 1, 0, 1, 5);   // abort on 5th RUN transfer
      run_eval(12, 0, 0, 0, 0);   // immediate restart
      run_eval(10, 1, 0, 2, 3);   // stall mid-RUN
      run_eval(10, 0, 2, 3, 4);   // async reset mid-RUN
      for (int i = 0; i < 12; i++)
         run_eval($urandom_range(0, 40), 0, $urandom_range(0, 2), 0, 0);

      repeat (4) @(posedge CLK);
      #1;
      chk("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
